cpu2axi_master: RTL and testbench

- Bridges a single-outstanding CPU load/store port onto an AXI4 master interface.
- Feeds the AXI-to-RAM slave stage directly, or feeds it through the interconnect.
- Every request becomes exactly one single-beat INCR transaction of full DATA_WIDTH.
- Read data, or write completion, is returned to the core as a one-cycle response pulse.

---
 rtl/cpu2axi_master.sv | 122 ++++++++++++
 tb/tb_cpu2axi_master.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu2axi_master.sv
// cpu2axi_master: single-outstanding CPU load/store port to AXI4 single-beat master.
module cpu2axi_master #(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CORE_ID    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ID_W_WIDTH-1:0]   axi_awid,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic [ID_W_WIDTH-1:0]   axi_bid,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic [ID_R_WIDTH-1:0]   axi_arid,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [ID_R_WIDTH-1:0]   axi_rid,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready
);
  localparam int LSB = $clog2(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] amask = ~ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ID_W_WIDTH-1:0] wid = ID_W_WIDTH'(CORE_ID);
  localparam logic [ID_R_WIDTH-1:0] rid = ID_R_WIDTH'(CORE_ID);
  typedef enum logic [2:0] {IDLE, AR, R, WR, B, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic aw_done, w_done, accept;
  assign req_ready   = state == IDLE;
  assign accept      = req_valid && req_ready;
  assign resp_valid  = state == RESP;
  assign axi_arvalid = state == AR;
  assign axi_rready  = state == R;
  assign axi_awvalid = state == WR && !aw_done;
  assign axi_wvalid  = state == WR && !w_done;
  assign axi_bready  = state == B;
  assign axi_awid    = wid;
  assign axi_arid    = rid;
  assign axi_awaddr  = addr_q;
  assign axi_araddr  = addr_q;
  assign axi_awlen   = 8'd0;
  assign axi_arlen   = 8'd0;
  assign axi_awsize  = 3'(LSB);
  assign axi_arsize  = 3'(LSB);
  assign axi_awburst = 2'b01;
  assign axi_arburst = 2'b01;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = axi_wvalid;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? (req_we ? WR : AR) : IDLE;
      AR:      state_n = axi_arready ? R : AR;
      R:       state_n = axi_rvalid ? RESP : R;
      WR:      state_n = (aw_done || axi_awready) && (w_done || axi_wready) ? B : WR;
      B:       state_n = axi_bvalid ? RESP : B;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= req_addr & amask;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (axi_awvalid && axi_awready) aw_done <= 1'b1;
      if (axi_wvalid && axi_wready) w_done <= 1'b1;
      if (axi_rready && axi_rvalid) begin
        resp_rdata <= axi_rdata;
        resp_err   <= axi_rid != rid || !axi_rlast;
      end
      if (axi_bready && axi_bvalid) begin
        resp_rdata <= '0;
        resp_err   <= axi_bid != wid;
      end
    end
  end
endmodule

// File: tb/tb_cpu2axi_master.sv
// tb_cpu2axi_master: randomized load/store traffic against a word-array RAM model.
module tb_cpu2axi_master;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_we = 0;
  logic [15:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [3:0] req_wstrb = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0] axi_awid, axi_arid, axi_bid = 0, axi_rid = 0;
  logic [15:0] axi_awaddr, axi_araddr;
  logic [7:0] axi_awlen, axi_arlen;
  logic [2:0] axi_awsize, axi_arsize;
  logic [1:0] axi_awburst, axi_arburst;
  logic axi_awvalid, axi_wvalid, axi_wlast, axi_bready, axi_arvalid, axi_rready;
  logic axi_awready = 0, axi_wready = 0, axi_bvalid = 0, axi_arready = 0, axi_rvalid = 0, axi_rlast = 0;
  logic [31:0] axi_wdata, axi_rdata = 0;
  logic [3:0] axi_wstrb;
  int n_vec = 0, n_err = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [31:0] mem [0:16383];

  cpu2axi_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n) begin
    if (axi_awvalid && axi_awready) aw_hs <= aw_hs + 1;
    if (axi_wvalid && axi_wready) w_hs <= w_hs + 1;
    if (axi_bvalid && axi_bready) b_hs <= b_hs + 1;
    if (axi_arvalid && axi_arready) ar_hs <= ar_hs + 1;
    if (axi_rvalid && axi_rready) r_hs <= r_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_load(input logic [15:0] a, input int ar_dly, input int r_dly,
                         input logic [3:0] id, input logic last, input logic hold);
    logic [31:0] d;
    int ar0, r0, aw0;
    d = mem[a[15:2]];
    ar0 = ar_hs; r0 = r_hs; aw0 = aw_hs;
    req_valid = 1; req_we = 0; req_addr = a; req_wdata = $urandom; req_wstrb = 4'($urandom);
    check("req_ready_idle", 64'(req_ready), 1);
    @(negedge clk);
    if (!hold) req_valid = 0;
    check("arlen", 64'(axi_arlen), 0);
    check("arsize", 64'(axi_arsize), 2);
    check("arburst", 64'(axi_arburst), 1);
    check("arid", 64'(axi_arid), 0);
    for (int t = 0; t <= ar_dly; t++) begin
      check("arvalid", 64'(axi_arvalid), 1);
      check("araddr", 64'(axi_araddr), 64'(a & 16'hfffc));
      if (hold) check("req_ready_busy", 64'(req_ready), 0);
      axi_arready = t == ar_dly;
      @(negedge clk);
    end
    axi_arready = 0;
    for (int t = 0; t <= r_dly; t++) begin
      check("rready", 64'(axi_rready), 1);
      check("arvalid_in_r", 64'(axi_arvalid), 0);
      if (hold) check("req_ready_busy", 64'(req_ready), 0);
      axi_rvalid = t == r_dly;
      axi_rdata = axi_rvalid ? d : $urandom;
      axi_rid = id; axi_rlast = last;
      @(negedge clk);
    end
    axi_rvalid = 0;
    req_valid = 0;
    check("load_resp_valid", 64'(resp_valid), 1);
    check("load_rdata", 64'(resp_rdata), 64'(d));
    check("load_err", 64'(resp_err), 64'(id != 0 || !last));
    check("ar_count", 64'(ar_hs - ar0), 1);
    check("r_count", 64'(r_hs - r0), 1);
    check("no_aw_on_load", 64'(aw_hs - aw0), 0);
    @(negedge clk);
    check("resp_pulse_end", 64'(resp_valid), 0);
    check("req_ready_after", 64'(req_ready), 1);
  endtask

  task automatic do_store(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int aw_dly, input int w_dly, input int b_dly, input logic [3:0] id);
    logic ag, wg;
    int aw0, w0, b0, ar0;
    ag = 0; wg = 0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs;
    req_valid = 1; req_we = 1; req_addr = a; req_wdata = wd; req_wstrb = ws;
    check("req_ready_idle", 64'(req_ready), 1);
    @(negedge clk);
    req_valid = 0;
    check("awlen", 64'(axi_awlen), 0);
    check("awsize", 64'(axi_awsize), 2);
    check("awburst", 64'(axi_awburst), 1);
    check("awid", 64'(axi_awid), 0);
    for (int t = 0; t < 40 && !(ag && wg); t++) begin
      check("awvalid", 64'(axi_awvalid), 64'(!ag));
      check("wvalid", 64'(axi_wvalid), 64'(!wg));
      check("bready_early", 64'(axi_bready), 0);
      if (!ag) check("awaddr", 64'(axi_awaddr), 64'(a & 16'hfffc));
      if (!wg) begin
        check("wdata", 64'(axi_wdata), 64'(wd));
        check("wstrb", 64'(axi_wstrb), 64'(ws));
        check("wlast", 64'(axi_wlast), 1);
      end
      axi_awready = t >= aw_dly;
      axi_wready = t >= w_dly;
      ag = ag || t >= aw_dly;
      wg = wg || t >= w_dly;
      @(negedge clk);
    end
    axi_awready = 0; axi_wready = 0;
    for (int t = 0; t <= b_dly; t++) begin
      check("bready", 64'(axi_bready), 1);
      check("aw_w_idle_in_b", 64'({axi_awvalid, axi_wvalid}), 0);
      axi_bvalid = t == b_dly;
      axi_bid = id;
      @(negedge clk);
    end
    axi_bvalid = 0;
    for (int b = 0; b < 4; b++) if (ws[b]) mem[a[15:2]][8*b +: 8] = wd[8*b +: 8];
    check("store_resp_valid", 64'(resp_valid), 1);
    check("store_err", 64'(resp_err), 64'(id != 0));
    check("store_rdata", 64'(resp_rdata), 0);
    check("aw_count", 64'(aw_hs - aw0), 1);
    check("w_count", 64'(w_hs - w0), 1);
    check("b_count", 64'(b_hs - b0), 1);
    check("no_ar_on_store", 64'(ar_hs - ar0), 0);
    @(negedge clk);
    check("resp_pulse_end", 64'(resp_valid), 0);
    check("req_ready_after", 64'(req_ready), 1);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 0;
    mem[16'h0010 >> 2] = 32'hdeadbeef;
    #1;
    check("rst_outputs", 64'({axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, axi_rready, resp_valid, resp_err}), 0);
    check("rst_rdata", 64'(resp_rdata), 0);
    check("rst_awaddr", 64'(axi_awaddr), 0);
    check("rst_req_ready", 64'(req_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_load(16'h0013, 0, 0, 4'h0, 1, 0);
    do_store(16'h0020, 32'h11223344, 4'b0101, 0, 0, 0, 4'h0);
    do_load(16'h0020, 0, 0, 4'h0, 1, 0);
    check("ram_readback", 64'(resp_rdata), 64'h00220044);
    do_store(16'h0024, 32'hcafef00d, 4'b1111, 5, 0, 1, 4'h0);
    do_store(16'h0028, 32'h0badf00d, 4'b1100, 0, 3, 0, 4'h0);
    do_store(16'h0024, 32'hffffffff, 4'b0000, 2, 2, 0, 4'h0);
    do_load(16'h0024, 1, 2, 4'h3, 1, 0);
    do_load(16'h0028, 0, 0, 4'h0, 0, 0);
    do_store(16'h0030, 32'h12345678, 4'b1111, 0, 0, 0, 4'h5);
    do_load(16'h0010, 2, 3, 4'h0, 1, 1);
    // abort a load mid-R with an asynchronous reset
    begin
      int r0;
      r0 = r_hs;
      req_valid = 1; req_we = 0; req_addr = 16'h0010;
      @(negedge clk);
      req_valid = 0;
      axi_arready = 1;
      @(negedge clk);
      axi_arready = 0;
      check("in_r_before_reset", 64'(axi_rready), 1);
      #2 rst_n = 0;
      #1;
      check("rst_async_valids", 64'({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid}), 0);
      check("rst_async_resp", 64'(resp_valid), 0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
        check("post_rst_resp", 64'(resp_valid), 0);
        check("post_rst_ready", 64'(req_ready), 1);
        @(negedge clk);
      end
      check("post_rst_no_r", 64'(r_hs - r0), 0);
    end
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      logic [3:0] id;
      a = 16'($urandom_range(0, 63));
      id = $urandom_range(0, 7) == 0 ? 4'($urandom_range(1, 15)) : 4'h0;
      if ($urandom_range(0, 1))
        do_store(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), id);
      else
        do_load(a, $urandom_range(0, 3), $urandom_range(0, 3), id,
                $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
